tiny_pairing_core: RTL and testbench

- Small GF(3^97) datapath core: a 64 x 198-bit register file shared between a host port and an internal microsequencer.
- The host loads the operands xp, yp, xq and yq, then releases the bus.
- The sequencer runs a fixed 12-instruction trit-wise add/sub/negate program, writes t0..t5 and R0..R5, and raises done.
- The core sits behind a simple host command port as the arithmetic back-end of the pairing engine.

---
 rtl/tiny_pairing_core.sv | 110 +++++++++++
 tb/tb_tiny_pairing_core.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tiny_pairing_core.sv
// rtl/tiny_pairing_core.sv - GF(3^97) register file with host port and a fixed
// 12-step trit-wise add/sub/negate microsequencer.
module tiny_pairing_core #(
  parameter int W        = 198,
  parameter int PROG_LEN = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sel,
  input  logic [5:0]   addr,
  input  logic         w,
  input  logic [W-1:0] data,
  output logic [W-1:0] out,
  output logic         done
);

  localparam int TRITS = 97;

  localparam logic [5:0] A_XP = 6'd3,  A_YP = 6'd5,  A_XQ = 6'd6,  A_YQ = 6'd7;
  localparam logic [5:0] A_T0 = 6'd9,  A_T1 = 6'd10, A_T2 = 6'd11, A_T3 = 6'd12;
  localparam logic [5:0] A_T4 = 6'd13, A_T5 = 6'd14, A_R0 = 6'd15, A_R1 = 6'd17;
  localparam logic [5:0] A_R2 = 6'd18, A_R3 = 6'd19, A_R4 = 6'd20, A_R5 = 6'd21;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_NEG} op_t;

  state_t       state, state_next;
  logic [3:0]   pc;
  logic         running;
  logic [W-1:0] regs [64];

  op_t          op;
  logic [5:0]   src_a, src_b, dst;
  logic [W-1:0] alu_result;

  // Code 11 decodes as 0; NEG is computed as 0 - a so all ops share one adder.
  function automatic logic [1:0] trit_op(input logic [1:0] a, input logic [1:0] b, input op_t o);
    logic [2:0] x, y, ny, s;
    x  = (o == OP_NEG || a == 2'b11) ? 3'd0 : {1'b0, a};
    y  = (o == OP_NEG) ? ((a == 2'b11) ? 3'd0 : {1'b0, a}) : ((b == 2'b11) ? 3'd0 : {1'b0, b});
    ny = (o == OP_ADD || y == 3'd0) ? y : 3'd3 - y;
    s  = x + ny;
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  always_comb begin
    op = OP_ADD; src_a = A_XP; src_b = A_XQ; dst = A_T0;
    case (pc)
      4'd0:    begin op = OP_ADD; src_a = A_XP; src_b = A_XQ; dst = A_T0; end
      4'd1:    begin op = OP_ADD; src_a = A_YP; src_b = A_YQ; dst = A_T1; end
      4'd2:    begin op = OP_SUB; src_a = A_XP; src_b = A_XQ; dst = A_T2; end
      4'd3:    begin op = OP_SUB; src_a = A_YP; src_b = A_YQ; dst = A_T3; end
      4'd4:    begin op = OP_NEG; src_a = A_T0; src_b = A_T0; dst = A_T4; end
      4'd5:    begin op = OP_ADD; src_a = A_T1; src_b = A_T2; dst = A_T5; end
      4'd6:    begin op = OP_ADD; src_a = A_T0; src_b = A_T4; dst = A_R0; end
      4'd7:    begin op = OP_SUB; src_a = A_T5; src_b = A_T3; dst = A_R1; end
      4'd8:    begin op = OP_ADD; src_a = A_T2; src_b = A_T2; dst = A_R2; end
      4'd9:    begin op = OP_NEG; src_a = A_T3; src_b = A_T3; dst = A_R3; end
      4'd10:   begin op = OP_SUB; src_a = A_T1; src_b = A_T4; dst = A_R4; end
      4'd11:   begin op = OP_ADD; src_a = A_T5; src_b = A_R2; dst = A_R5; end
      default: begin op = OP_ADD; src_a = A_XP; src_b = A_XQ; dst = A_T0; end
    endcase
  end

  always_comb begin
    alu_result = '0;
    for (int i = 0; i < TRITS; i++)
      alu_result[2*i +: 2] = trit_op(regs[src_a][2*i +: 2], regs[src_b][2*i +: 2], op);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!sel) state_next = RUN;
      RUN:     if (pc == 4'(PROG_LEN - 1)) state_next = DONE;
      DONE:    if (sel) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN);
    done    = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       pc <= '0;
    else if (running) pc <= pc + 4'd1;
    else              pc <= '0;
  end

  // The sequencer owns the write port for the whole run; host writes are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) regs[i] <= '0;
    end else if (running) begin
      regs[dst] <= alu_result;
    end else if (sel && w) begin
      regs[addr] <= data;
    end
  end

  assign out = (sel && !running) ? regs[addr] : '0;

endmodule

// File: tb/tb_tiny_pairing_core.sv
// tb/tb_tiny_pairing_core.sv - directed vector bench for tiny_pairing_core.
module tb_tiny_pairing_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         sel;
  logic [5:0]   addr;
  logic         w;
  logic [197:0] data;
  logic [197:0] out;
  logic         done;

  int n_cmp  = 0;
  int n_fail = 0;

  tiny_pairing_core dut (
    .clk(clk), .reset(reset), .sel(sel), .addr(addr),
    .w(w), .data(data), .out(out), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] xp, yp, xq, yq;
    logic       full;
    logic [1:0] exp [12];
  } vec_t;

  vec_t vecs [5];
  int   dst_addr [12] = '{9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};

  function automatic logic [197:0] expand(input logic [1:0] c, input logic full);
    logic [197:0] r;
    r = '0;
    if (full) for (int i = 0; i < 97; i++) r[2*i +: 2] = c;
    else      r[1:0] = c;
    return r;
  endfunction

  task automatic check(input string name, input logic [197:0] act, input logic [197:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [5:0] a, input logic [197:0] d);
    sel = 1'b1; w = 1'b1; addr = a; data = d;
    @(posedge clk); #1;
    w = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [5:0] a, input logic [197:0] exp);
    sel = 1'b1; addr = a;
    #1;
    check(name, out, exp);
  endtask

  task automatic run_wait(output int lat);
    sel = 1'b0; lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    sel = 1'b1;
  endtask

  logic [197:0] va, vb;
  int lat;

  initial begin
    vecs[0].xp = 2'd1; vecs[0].yp = 2'd2; vecs[0].xq = 2'd2; vecs[0].yq = 2'd2; vecs[0].full = 1'b0;
    vecs[0].exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1};
    vecs[1].xp = 2'd1; vecs[1].yp = 2'd1; vecs[1].xq = 2'd1; vecs[1].yq = 2'd0; vecs[1].full = 1'b1;
    vecs[1].exp = '{2'd2, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd1};
    vecs[2].xp = 2'd2; vecs[2].yp = 2'd0; vecs[2].xq = 2'd0; vecs[2].yq = 2'd1; vecs[2].full = 1'b1;
    vecs[2].exp = '{2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
    vecs[3].xp = 2'd3; vecs[3].yp = 2'd3; vecs[3].xq = 2'd0; vecs[3].yq = 2'd3; vecs[3].full = 1'b1;
    vecs[3].exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[4].xp = 2'd0; vecs[4].yp = 2'd2; vecs[4].xq = 2'd1; vecs[4].yq = 2'd1; vecs[4].full = 1'b1;
    vecs[4].exp = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd0};

    reset = 1'b0; sel = 1'b1; w = 1'b0; addr = '0; data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("reset_done", {197'd0, done}, 198'd0);
    read_check("reset_xp", 6'd3, 198'd0);

    // load and readback, done must stay low while the host holds the bus
    va = 198'h288162298554054820552a05426081a1842886a58916a6249;
    vb = 198'h2895955069089214054596a189a4420556589054140941695;
    write_reg(6'd3, va); write_reg(6'd6, va);
    write_reg(6'd5, vb); write_reg(6'd7, vb);
    read_check("load_xp", 6'd3, va);
    read_check("load_yp", 6'd5, vb);
    read_check("load_xq", 6'd6, va);
    read_check("load_yq", 6'd7, vb);
    check("load_done_low", {197'd0, done}, 198'd0);

    for (int v = 0; v < 5; v++) begin
      write_reg(6'd3, expand(vecs[v].xp, vecs[v].full));
      write_reg(6'd5, expand(vecs[v].yp, vecs[v].full));
      write_reg(6'd6, expand(vecs[v].xq, vecs[v].full));
      write_reg(6'd7, expand(vecs[v].yq, vecs[v].full));
      run_wait(lat);
      check($sformatf("v%0d_latency", v), 198'(lat), 198'd13);
      for (int k = 0; k < 12; k++)
        read_check($sformatf("v%0d_res%0d", v, k), 6'(dst_addr[k]), expand(vecs[v].exp[k], vecs[v].full));
      @(posedge clk); #1;
    end

    // upper bits of an operand are ignored by the ALU but stored verbatim
    va = 198'h1 | (198'hF << 194);
    write_reg(6'd3, va); write_reg(6'd6, '0);
    write_reg(6'd5, '0); write_reg(6'd7, '0);
    read_check("mask_xp_verbatim", 6'd3, va);
    run_wait(lat);
    check("mask_latency", 198'(lat), 198'd13);
    read_check("mask_t0", 6'd9, 198'h1);
    read_check("mask_t2", 6'd11, 198'h1);
    @(posedge clk); #1;

    // write lockout during run, including a sel=1 blip
    va = expand(2'd1, 1'b1);
    write_reg(6'd3, va);
    sel = 1'b0; lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    w = 1'b1; addr = 6'd3; data = ~va;
    #1 check("lock_out_sel0", out, 198'd0);
    @(posedge clk); #1; lat++;
    sel = 1'b1;
    #1 check("lock_out_sel1", out, 198'd0);
    @(posedge clk); #1; lat++;
    sel = 1'b0; w = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) break;
      @(posedge clk); #1; lat++;
    end
    check("lock_latency", 198'(lat), 198'd13);
    read_check("lock_xp_kept", 6'd3, va);
    @(posedge clk); #1;

    // reset in the middle of a run at pc=5
    write_reg(6'd5, expand(2'd2, 1'b1));
    sel = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    #1 check("midrst_done", {197'd0, done}, 198'd0);
    @(posedge clk); #1;
    reset = 1'b1; sel = 1'b1;
    for (int a = 0; a < 64; a++)
      read_check($sformatf("midrst_reg%0d", a), 6'(a), 198'd0);
    check("midrst_done_after", {197'd0, done}, 198'd0);
    run_wait(lat);
    check("midrst_rerun_latency", 198'(lat), 198'd13);
    read_check("midrst_rerun_r5", 6'd21, 198'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
